// File: rtl/seven_seg_chain_driver.sv
// Hex-to-seven-segment decoder and serialiser for a daisy chain of 74HC595-style registers.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading zero digits, digit 0 always shown).
module seven_seg_chain_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 4,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    CLK,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    output logic                    o_ds,
    output logic                    o_sh_clk,
    output logic                    o_latch,
    output logic                    o_busy
);

    localparam int SW = 8 * NUM_DIGITS;
    localparam int BW = $clog2(SW + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    localparam logic [BW-1:0] BIT_TOTAL = BW'(SW);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Segment pattern g..a for one hex nibble, 1 = lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    state_t          state, state_next;
    logic [DW-1:0]   div_cnt, div_next;
    logic [BW-1:0]   bit_cnt, bit_next;
    logic [SW-1:0]   shift_data, shift_next;
    logic [SW-1:0]   seg_bytes;
    logic            div_done;
    logic            ds_next, sh_next, latch_next, busy_next;

    // Digit d lands in seg_bytes[8d+7:8d]; the MSB of the vector is shifted out first,
    // so digit NUM_DIGITS-1 leads and digit 0 ends up nearest the data pin.
    always_comb begin : encode
        logic       zero_run;
        logic [6:0] seg;
        seg_bytes = '0;
        zero_run  = 1'b1;
        seg       = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (i_value[4*d +: 4] == 4'h0) && (d != 0);
            seg      = (BLANK_EN && zero_run) ? 7'h00 : hex_to_seg(i_value[4*d +: 4]);
            seg_bytes[8*d +: 8] = {8{COMMON_ANODE != 0}} ^ {i_dp[d], seg};
        end
    end

    assign div_done = (div_cnt == DIV_LAST);

    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_data;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = SETUP;
                    shift_next = seg_bytes;
                    bit_next   = BIT_TOTAL;
                    div_next   = '0;
                end
            end
            SETUP: begin
                if (div_done) begin
                    state_next = HIGH;
                    div_next   = '0;
                end else begin
                    div_next = div_cnt + DW'(1);
                end
            end
            HIGH: begin
                if (div_done) begin
                    div_next   = '0;
                    bit_next   = bit_cnt - BW'(1);
                    shift_next = shift_data << 1;
                    state_next = (bit_cnt == BW'(1)) ? LATCH : SETUP;
                end else begin
                    div_next = div_cnt + DW'(1);
                end
            end
            LATCH: begin
                if (div_done) begin
                    state_next = IDLE;
                    div_next   = '0;
                end else begin
                    div_next = div_cnt + DW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                div_next   = '0;
                bit_next   = '0;
            end
        endcase

        // Pins are registered from the next state so they change on the same edge as the FSM.
        ds_next    = ((state_next == SETUP) || (state_next == HIGH)) ? shift_next[SW-1] : 1'b0;
        sh_next    = (state_next == HIGH);
        latch_next = (state_next == LATCH);
        busy_next  = (state_next != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (i_reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            // NOTE: the shadow register is reset too so an aborted transfer leaves no stale data behind.
            shift_data <= '0;
            o_ds       <= 1'b0;
            o_sh_clk   <= 1'b0;
            o_latch    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_next;
            div_cnt    <= div_next;
            bit_cnt    <= bit_next;
            shift_data <= shift_next;
            o_ds       <= ds_next;
            o_sh_clk   <= sh_next;
            o_latch    <= latch_next;
            o_busy     <= busy_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_chain_driver.sv
// Self-checking bench for seven_seg_chain_driver: directed and randomised transfers compared
// against a digit-level reference model; honours LEAD_ZERO_BLANK_EN when defined.
`timescale 1ns/1ps
module tb_seven_seg_chain_driver;

    localparam int ND = 2;
    localparam int CD = 2;
    localparam int SW = 8 * ND;
    localparam int BUSY_LEN = (16 * ND + 1) * CD;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            i_reset, i_start;
    logic [4*ND-1:0] i_value;
    logic [ND-1:0]   i_dp;
    logic            o_ds, o_sh_clk, o_latch, o_busy;

    logic            ca_start;
    logic [3:0]      ca_value;
    logic [0:0]      ca_dp;
    logic            ca_ds, ca_sh_clk, ca_latch, ca_busy;

    seven_seg_chain_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .COMMON_ANODE(0)) u_dut (
        .CLK(CLK), .i_reset(i_reset), .i_start(i_start), .i_value(i_value), .i_dp(i_dp),
        .o_ds(o_ds), .o_sh_clk(o_sh_clk), .o_latch(o_latch), .o_busy(o_busy)
    );

    seven_seg_chain_driver #(.NUM_DIGITS(1), .CLK_DIV(1), .COMMON_ANODE(1)) u_ca (
        .CLK(CLK), .i_reset(i_reset), .i_start(ca_start), .i_value(ca_value), .i_dp(ca_dp),
        .o_ds(ca_ds), .o_sh_clk(ca_sh_clk), .o_latch(ca_latch), .o_busy(ca_busy)
    );

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Expected shift stream: digit d occupies bits [8d+7:8d], first-shifted bit is the MSB.
    function automatic logic [31:0] model(input logic [15:0] v, input logic [3:0] dp,
                                          input int nd, input int ca);
        int         top;
        logic [7:0] b;
        logic [3:0] nib;
        model = '0;
        top   = 0;
        for (int d = 0; d < nd; d++) if (v[4*d +: 4] != 4'h0) top = d;
        for (int d = 0; d < nd; d++) begin
            nib = v[4*d +: 4];
            b   = seg_tab[nib];
`ifdef LEAD_ZERO_BLANK_EN
            if (d > top) b = 8'h00;
`endif
            b[7] = dp[d];
            if (ca != 0) b = ~b;
            model[8*d +: 8] = b;
        end
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-transfer record built by the pin monitor.
    typedef struct {
        logic [SW-1:0] bits;
        logic [31:0]   exp;
        int            rises;
        int            busy_len;
        int            latch_cnt;
        int            latch_len;
        int            viol;
        int            gap;
    } rec_t;

    rec_t            recs[$];
    rec_t            cur;
    int              idle_run = 0, hi_run = 0, lo_run = 0, idle_viol = 0;
    bit              mb, ms, md, ml, mb_prev = 0, ms_prev = 0, ml_prev = 0, ds_hi = 0;
    logic [4*ND-1:0] val_at_edge = '0;
    logic [ND-1:0]   dp_at_edge = '0;

    always @(posedge CLK) begin
        val_at_edge = i_value;
        dp_at_edge  = i_dp;
    end

    always @(negedge CLK) begin
        mb = o_busy; ms = o_sh_clk; md = o_ds; ml = o_latch;
        if (mb && !mb_prev) begin
            cur = '{default: 0};
            cur.gap = idle_run;
            cur.exp = model({8'h00, val_at_edge}, {2'b00, dp_at_edge}, ND, 0);
            hi_run  = 0;
            lo_run  = 0;
        end
        if (mb) begin
            cur.busy_len++;
            if (ms && !ms_prev) begin
                cur.rises++;
                cur.bits = {cur.bits[SW-2:0], md};
                if (lo_run != CD) cur.viol++;
                ds_hi  = md;
                lo_run = 0;
            end
            if (ms) begin
                hi_run++;
                if (md != ds_hi) cur.viol++;
            end
            if (!ms && ms_prev) begin
                if (hi_run != CD) cur.viol++;
                hi_run = 0;
            end
            if (!ms && !ml) lo_run++;
            if (ml) begin
                if (!ml_prev) cur.latch_cnt++;
                cur.latch_len++;
                if (ms || md) cur.viol++;
            end
        end else begin
            if (mb_prev) recs.push_back(cur);
            idle_run = mb_prev ? 1 : idle_run + 1;
            if (md || ms || ml) idle_viol++;
        end
        mb_prev = mb; ms_prev = ms; ml_prev = ml;
    end

    task automatic wait_rec(output rec_t r, output bit ok);
        ok = 1'b0;
        r  = '{default: 0};
        for (int c = 0; c < 400 && !ok; c++) begin
            if (recs.size() > 0) begin
                r  = recs.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
    endtask

    task automatic check_rec(input string tag, input rec_t r, input logic [31:0] exp_bits);
        check({tag, "_bits"},      r.bits,      exp_bits);
        check({tag, "_rises"},     r.rises,     SW);
        check({tag, "_busy_len"},  r.busy_len,  BUSY_LEN);
        check({tag, "_latches"},   r.latch_cnt, 1);
        check({tag, "_latch_len"}, r.latch_len, CD);
        check({tag, "_timing"},    r.viol,      0);
    endtask

    task automatic run_ca(input logic [3:0] v, input logic dp, output logic [7:0] got,
                          output int blen, output int rises, output int latches, output bit first_busy);
        bit psh, pl;
        @(negedge CLK);
        ca_value = v; ca_dp = dp; ca_start = 1'b1;
        @(negedge CLK);
        ca_start   = 1'b0;
        ca_value   = ~v;
        first_busy = ca_busy;
        got = '0; blen = 0; rises = 0; latches = 0; psh = 0; pl = 0;
        for (int c = 0; c < 40; c++) begin
            if (ca_busy) blen++;
            if (ca_sh_clk && !psh) begin
                rises++;
                got = {got[6:0], ca_ds};
            end
            if (ca_latch && !pl) latches++;
            psh = ca_sh_clk;
            pl  = ca_latch;
            @(negedge CLK);
        end
    endtask

    initial begin
        rec_t       r;
        bit         ok, fb;
        logic [7:0] v8, cg;
        logic [1:0] dp;
        logic [31:0] e;
        int         bl, rs, lc, nrec;

        i_reset = 1'b1; i_start = 1'b0; i_value = '0; i_dp = '0;
        ca_start = 1'b0; ca_value = '0; ca_dp = '0;
        repeat (3) @(negedge CLK);
        check("reset_ds", o_ds, 0);
        check("reset_sh_clk", o_sh_clk, 0);
        check("reset_latch", o_latch, 0);
        check("reset_busy", o_busy, 0);
        check("reset_ca_busy", ca_busy, 0);
        i_reset = 1'b0;
        @(negedge CLK);

        // 0x3A, no decimal points: 4F then 77; inputs change right after capture.
        i_value = 8'h3A; i_dp = 2'b00; i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0; i_value = 8'hFF; i_dp = 2'b11;
        check("start_latency_busy", o_busy, 1);
        wait_rec(r, ok);
        check("d3A_seen", ok, 1);
        check_rec("d3A", r, 32'h4F77);

        // All zero with dp on digit 0.
        i_value = 8'h00; i_dp = 2'b01; i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        e = 32'h00BF;
`else
        e = 32'h3FBF;
`endif
        wait_rec(r, ok);
        check("d00_seen", ok, 1);
        check_rec("d00", r, e);

        // Leading zero carrying a decimal point: dp stays lit even when blanked.
        i_value = 8'h05; i_dp = 2'b10; i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        check("d05_first_ds", o_ds, 1);
`ifdef LEAD_ZERO_BLANK_EN
        e = 32'h806D;
`else
        e = 32'hBF6D;
`endif
        wait_rec(r, ok);
        check("d05_seen", ok, 1);
        check_rec("d05", r, e);

        // Random transfers; start pulses and input churn while busy must be ignored.
        for (int t = 0; t < 12; t++) begin
            v8 = 8'($urandom);
            if (t % 3 == 0) v8[7:4] = 4'h0;
            if (t % 6 == 0) v8[3:0] = 4'h0;
            dp = 2'($urandom);
            e  = model({8'h00, v8}, {2'b00, dp}, ND, 0);
            i_value = v8; i_dp = dp; i_start = 1'b1;
            @(negedge CLK);
            check($sformatf("rnd%0d_first_ds", t), o_ds, e[SW-1]);
            for (int c = 0; c < 30; c++) begin
                i_start = 1'($urandom);
                i_value = 8'($urandom);
                i_dp    = 2'($urandom);
                @(negedge CLK);
            end
            i_start = 1'b0;
            wait_rec(r, ok);
            check($sformatf("rnd%0d_seen", t), ok, 1);
            check_rec($sformatf("rnd%0d", t), r, e);
            repeat (3) @(negedge CLK);
            check($sformatf("rnd%0d_not_queued", t), o_busy, 0);
        end
        check("no_stray_transfers", recs.size(), 0);

        // Start held high for 200 cycles with inputs changing every cycle.
        i_start = 1'b1;
        for (int c = 0; c < 200; c++) begin
            i_value = 8'($urandom);
            i_dp    = 2'($urandom);
            @(negedge CLK);
        end
        i_start = 1'b0;
        for (int c = 0; c < 200 && (o_busy || recs.size() < 3); c++) @(negedge CLK);
        nrec = recs.size();
        check("b2b_count", nrec, 3);
        for (int k = 0; k < nrec; k++) begin
            r = recs.pop_front();
            check_rec($sformatf("b2b%0d", k), r, r.exp);
            if (k > 0) check($sformatf("b2b%0d_gap", k), r.gap, 1);
        end

        // Reset at cycle 20 of a transfer: pins clear on the next edge, no latch pulse.
        i_value = 8'h81; i_dp = 2'b10; i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        repeat (19) @(negedge CLK);
        i_reset = 1'b1;
        @(negedge CLK);
        check("abort_ds", o_ds, 0);
        check("abort_sh_clk", o_sh_clk, 0);
        check("abort_latch", o_latch, 0);
        check("abort_busy", o_busy, 0);
        i_reset = 1'b0;
        wait_rec(r, ok);
        check("abort_seen", ok, 1);
        check("abort_busy_len", r.busy_len, 20);
        check("abort_no_latch", r.latch_cnt, 0);
        repeat (10) @(negedge CLK);
        check("abort_no_restart", recs.size(), 0);

        i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        wait_rec(r, ok);
        check("after_abort_seen", ok, 1);
        check_rec("after_abort", r, 32'hFF06);

        // Start and reset together: reset wins.
        i_reset = 1'b1; i_start = 1'b1;
        @(negedge CLK);
        check("rst_start_busy", o_busy, 0);
        i_reset = 1'b0; i_start = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_start_no_xfer", recs.size(), 0);

        // Common-anode single digit: every shifted bit inverted.
        run_ca(4'h8, 1'b0, cg, bl, rs, lc, fb);
        check("ca8_first_busy", fb, 1);
        check("ca8_byte", cg, 8'h80);
        check("ca8_busy_len", bl, 17);
        check("ca8_rises", rs, 8);
        check("ca8_latches", lc, 1);
        check("ca8_idle_ds", ca_ds, 0);
        for (int t = 0; t < 4; t++) begin
            v8 = 8'($urandom);
            e  = model({12'h000, v8[3:0]}, {3'b000, v8[4]}, 1, 1);
            run_ca(v8[3:0], v8[4], cg, bl, rs, lc, fb);
            check($sformatf("ca_rnd%0d_byte", t), cg, e[7:0]);
            check($sformatf("ca_rnd%0d_busy_len", t), bl, 17);
        end

        check("idle_pins_low", idle_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
